// File: rtl/synapse_current.sv
`default_nettype none
// ============================================================================
//  Module      : synapse_current
//  Description : Single-synapse current generator feeding the dendrite adder.
//                Each spike addressed to this synapse adds the programmed
//                weight to an unsigned current. Between spikes the current
//                decays by current>>DECAY_SHIFT every DECAY_PERIOD cycles,
//                with a minimum step of 1 so that it always reaches zero.
//  Optional    : SYNAPSE_STD_EN enables short-term depression through an
//                efficacy register that scales the weight.
//  Ports       : clk            - clock, rising edge
//                reset          - synchronous, active-low reset
//                spike_valid    - spike event present this cycle
//                spike_addr     - target address of the spike event
//                cfg_valid      - config write request
//                cfg_ready      - config write accepted when valid & ready
//                cfg_weight     - unsigned weight to program
//                cfg_enable     - synapse enable to program
//                output_current - registered synaptic current to dendrite
//                active         - output_current != 0
//                sat_flag       - sticky addition-saturation flag
//  Revision    : 1.0 - initial release
// ============================================================================
module synapse_current #(
  parameter int WIDTH        = 16,
  parameter int ADDR_WIDTH   = 6,
  parameter int MY_ADDR      = 0,
  parameter int DECAY_SHIFT  = 3,
  parameter int DECAY_PERIOD = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  spike_valid,
  input  logic [ADDR_WIDTH-1:0] spike_addr,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [WIDTH-1:0]      cfg_weight,
  input  logic                  cfg_enable,
  output logic [WIDTH-1:0]      output_current,
  output logic                  active,
  output logic                  sat_flag
);

  localparam int                CNT_W    = (DECAY_PERIOD > 1) ? $clog2(DECAY_PERIOD) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DECAY_PERIOD - 1);
  localparam logic [WIDTH-1:0]  ALL_ONES = '1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DECAY = 2'd1,
    ST_CFG   = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   current_q, current_d;
  logic [WIDTH-1:0]   weight_q, weight_d;
  logic               enable_q, enable_d;
  logic               sat_q, sat_d;
  logic               cfg_ready_q, cfg_ready_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               cfg_accept;
  logic               spike_hit;
  logic               counting;
  logic               tick;
  logic [WIDTH-1:0]   decay_step;
  logic [WIDTH-1:0]   c1;
  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   eff_weight;

`ifdef SYNAPSE_STD_EN
  logic [WIDTH-1:0]   efficacy_q, efficacy_d;
  logic [CNT_W-1:0]   rec_cnt_q, rec_cnt_d;
  logic [2*WIDTH-1:0] product;
  logic               rec_tick;

  // Efficacy recovers on its own free-running counter so it also heals in IDLE.
  always_comb begin
    product    = {{WIDTH{1'b0}}, weight_q} * {{WIDTH{1'b0}}, efficacy_q};
    eff_weight = product[2*WIDTH-1:WIDTH];
    rec_tick   = (rec_cnt_q == CNT_LAST);
    rec_cnt_d  = rec_tick ? '0 : rec_cnt_q + CNT_W'(1);
    efficacy_d = efficacy_q;
    if (spike_hit) begin
      efficacy_d = efficacy_q - (efficacy_q >> 2);
    end
    if (rec_tick && (efficacy_d != ALL_ONES)) begin
      efficacy_d = efficacy_d + WIDTH'(1);
    end
    if (cfg_accept) begin
      efficacy_d = ALL_ONES;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      efficacy_q <= ALL_ONES;
      rec_cnt_q  <= '0;
    end else begin
      efficacy_q <= efficacy_d;
      rec_cnt_q  <= rec_cnt_d;
    end
  end
`else
  assign eff_weight = weight_q;
`endif

  always_comb begin
    cfg_accept = cfg_valid & cfg_ready_q;
    spike_hit  = spike_valid & (spike_addr == ADDR_WIDTH'(MY_ADDR)) & enable_q;

    // Counter only runs while a nonzero current is present; IDLE holds it at 0
    // so a fresh spike always starts a full period before the first decay.
    counting = (state_q != ST_IDLE) && (current_q != '0);
    tick     = counting && (cnt_q == CNT_LAST);
    cnt_d    = counting ? (tick ? '0 : cnt_q + CNT_W'(1)) : '0;

    decay_step = current_q >> DECAY_SHIFT;
    if ((decay_step == '0) && (current_q != '0)) begin
      decay_step = WIDTH'(1);
    end

    // Decay first, then add, through a single adder with carry detection.
    c1        = tick ? (current_q - decay_step) : current_q;
    sum       = {1'b0, c1} + (spike_hit ? {1'b0, eff_weight} : {(WIDTH+1){1'b0}});
    current_d = sum[WIDTH] ? ALL_ONES : sum[WIDTH-1:0];

    // A spike in the write cycle already used the old weight above.
    weight_d = cfg_accept ? cfg_weight : weight_q;
    enable_d = cfg_accept ? cfg_enable : enable_q;

    sat_d = sat_q;
    if (cfg_accept) begin
      sat_d = 1'b0;
    end
    if (sum[WIDTH]) begin
      sat_d = 1'b1;
    end

    if (cfg_accept) begin
      state_d = ST_CFG;
    end else if (current_d != '0) begin
      state_d = ST_DECAY;
    end else begin
      state_d = ST_IDLE;
    end

    cfg_ready_d = !cfg_accept;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      current_q   <= '0;
      weight_q    <= '0;
      enable_q    <= 1'b0;
      sat_q       <= 1'b0;
      cfg_ready_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      current_q   <= current_d;
      weight_q    <= weight_d;
      enable_q    <= enable_d;
      sat_q       <= sat_d;
      cfg_ready_q <= cfg_ready_d;
      cnt_q       <= cnt_d;
    end
  end

  assign output_current = current_q;
  assign active         = (current_q != '0);
  assign sat_flag       = sat_q;
  assign cfg_ready      = cfg_ready_q;

endmodule
`default_nettype wire
